bn_rr_arbiter_4: RTL
====================

# bn_rr_arbiter_4

Round-robin arbiter and scheduler that shares one DATA_WIDTH-wide output channel between four requesters. It issues a registered one-hot grant that drives a 4:1 AND-OR selector, and forwards the granted requester's data beats under a valid/ready handshake. Bursts end on `last` or at a programmable beat limit. It sits between four beat-producing sources and a single consumer on the lab board datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one requester's data word
- MAX_BEATS, 8, maximum beats per grant before forced re-arbitration (≥1)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  4  per-requester request / beat-valid; bit i belongs to requester i
- data  in  DATA_WIDTH*4  packed words; requester i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
- last  in  4  per-requester last-beat marker, qualified by req[i]
- out_ready  in  1  consumer accepts a beat when out_valid & out_ready
- grant  out  4  registered one-hot (or zero) grant
- out_valid  out  1  |(req & grant)
- out_data  out  DATA_WIDTH  AND-OR selection of data by grant; all zeros when grant = 0
- out_last  out  1  |(last & grant & req), or the forced-end condition (see Operation)
- ack  out  4  grant & {4{out_valid & out_ready}}; requester i's current beat is consumed

## Operation
- State: two-state FSM IDLE/BUSY, registered grant[3:0], priority pointer ptr[1:0], beat counter cnt (0..MAX_BEATS-1).
- Arbitration: search req starting at index ptr, then ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
- IDLE: grant = 0, out_valid = 0. If |req, load the winner's one-hot into grant, cnt <= 0, go to BUSY. Otherwise stay in IDLE.
- BUSY: grant is held. Each accepted beat (out_valid & out_ready) increments cnt.
- Burst end: an accepted beat that has either the granted last bit set or cnt = MAX_BEATS-1. On the end beat:
  - ptr <= granted index + 1 (mod 4).
  - Arbitrate again in the same cycle using the updated pointer, so the finishing requester has lowest priority.
  - If any req: load the new grant, cnt <= 0, stay in BUSY. Otherwise grant <= 0, go to IDLE.
- Forced end (cnt = MAX_BEATS-1 without last): out_last is asserted for that beat. The requester keeps requesting and resumes when it is granted again; there is no data loss.
- Granted requester drops req mid-burst without last: grant is held, out_valid = 0, cnt frozen. The burst continues when req returns. Other requesters wait.
- Not-accepted beat (out_ready = 0): no state change. The requester must hold data/last stable while req is high.
- Non-granted req bits never affect outputs during BUSY.
- Invariant: grant is zero or exactly one-hot at every cycle.

## Timing
- Reset (rst_n = 0 at a clk edge): next cycle grant = 0, ptr = 0, cnt = 0, state IDLE. Therefore out_valid = 0, out_data = 0, out_last = 0, ack = 0.
- Reset asserted mid-burst: grant drops at the next edge regardless of out_ready. The partial burst is abandoned.
- Latency: req rises in cycle N from IDLE → grant is set in cycle N+1 → the first beat can be accepted in cycle N+1.
- out_valid, out_data, out_last and ack are combinational from the registered grant and the current req/data/last/out_ready. There is no combinational path from req to grant.
- Back-to-back bursts: there is no idle bubble between requesters when another req is pending at the end beat.
- Throughput: one beat per cycle while req and out_ready stay high.

## Test plan
- Reset: drive rst_n = 0 with req = 4'b1111 → grant = 0, out_data = 0, out_valid = 0. Release reset → grant = 4'b0001 one cycle later.
- Round robin: all req held high, every beat has last, out_ready = 1 → grant sequence 0001, 0010, 0100, 1000, 0001, with one beat each and no idle cycles. out_data equals the granted word.
- Burst hold and backpressure: req = 4'b0101, requester 0 sends 3 beats with last on the third, out_ready toggles 1,0,1,1 → grant stays 0001 until the third beat is accepted, then becomes 0100. ack[0] pulses exactly 3 times.
- Beat limit: MAX_BEATS = 4, requester 2 never asserts last, requester 1 also requesting → after 4 accepted beats out_last = 1 and grant moves to 0010. Requester 2 is granted again after requester 1 finishes.
- Request drop mid-burst: requester 3 granted, req[3] low for 2 cycles while req[0] is high → grant stays 1000, out_valid = 0, cnt unchanged. The burst resumes when req[3] returns.
- Reset mid-burst: assert rst_n = 0 during beat 2 of a burst → grant = 0 next cycle and ptr = 0, so requester 0 wins first afterwards.

Source files
------------

// File: rtl/bn_rr_arbiter_4_if.sv
// Requester/consumer bundle for the four-way round-robin arbiter.
// The arbiter takes the slave view; the sources and consumer side take the master view.
interface bn_rr_arbiter_4_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]              req;
    logic [DATA_WIDTH*4-1:0] data;
    logic [3:0]              last;
    logic                    out_ready;
    logic [3:0]              grant;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_last;
    logic [3:0]              ack;

    modport master (
        output req, data, last, out_ready,
        input  grant, out_valid, out_data, out_last, ack
    );

    modport slave (
        input  req, data, last, out_ready,
        output grant, out_valid, out_data, out_last, ack
    );
endinterface

// File: rtl/bn_rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant steering an AND-OR data mux.
// Bursts end on the granted last bit or after MAX_BEATS accepted beats.
module bn_rr_arbiter_4 #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bn_rr_arbiter_4_if.slave   bus
);

    localparam int            CW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [1:0]            grant_idx;
    logic                  out_valid;
    logic                  out_last;
    logic                  beat_fire;
    logic                  limit_hit;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            arb_ptr;
    logic [1:0]            arb_idx;
    logic [3:0]            arb_win;
    logic                  arb_any;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) grant_idx = 2'(i);
        end
    end

    always_comb begin
        out_valid = |(bus.req & grant_q);
        beat_fire = out_valid & bus.out_ready;
        limit_hit = (cnt_q == CNT_LAST);
        out_last  = (|(bus.last & grant_q & bus.req)) | (out_valid & limit_hit);
        burst_end = beat_fire & out_last;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_data = out_data | (bus.data[DATA_WIDTH*i +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    // On an end beat the search starts just past the finishing requester.
    always_comb begin
        arb_ptr = burst_end ? (grant_idx + 2'd1) : ptr_q;
        arb_win = 4'b0000;
        arb_any = 1'b0;
        arb_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            arb_idx = arb_ptr + 2'(k);
            if (!arb_any && bus.req[arb_idx]) begin
                arb_win[arb_idx] = 1'b1;
                arb_any          = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_win;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            default: begin
                if (burst_end) begin
                    ptr_d = grant_idx + 2'd1;
                    cnt_d = '0;
                    if (arb_any) begin
                        grant_d = arb_win;
                    end else begin
                        grant_d = 4'b0000;
                        state_d = S_IDLE;
                    end
                end else if (beat_fire) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.ack       = grant_q & {4{beat_fire}};

endmodule
